// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential binary-to-BCD converter using the double-dabble (shift-and-add-3)
// algorithm, one input bit per clock. A conversion is accepted in IDLE, runs
// for exactly WIDTH cycles in SHIFT and then holds its result in DONE until the
// consumer takes it. With SIGNED=1 the input is two's complement: the block
// converts the magnitude and reports the sign separately.
//
// Parameters
//   WIDTH   binary input width in bits (2..32)
//   DIGITS  number of BCD output digits (1..10)
//   SIGNED  1: din is two's complement, 0: din is unsigned
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   din holds a value to convert
//   in_ready   block can accept input (high only in IDLE)
//   din        binary value to convert
//   out_valid  result complete (high only in DONE)
//   out_ready  consumer accepts the result
//   bcd        BCD magnitude, digit k in bits [4k+3:4k], units in [3:0]
//   sign       input was negative (always 0 when SIGNED=0)
//   overflow   magnitude >= 10^DIGITS; bcd then holds magnitude mod 10^DIGITS
//   busy       conversion in progress (SHIFT state)
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
   parameter int WIDTH  = 10,
   parameter int DIGITS = 3,
   parameter int SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      din,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  sign,
   output logic                  overflow,
   output logic                  busy
);

   // Smallest counter that can hold WIDTH-1, never narrower than one bit.
   localparam int CNT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      mag_q,   mag_d;
   logic [4*DIGITS-1:0]   bcd_q,   bcd_d;
   logic                  sign_q,  sign_d;
   logic                  ovf_q,   ovf_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;

   // ---------------------------------------------------------------------------
   // Input magnitude: for a negative signed input take the WIDTH-bit
   // two's-complement negation. The most negative value negates to itself,
   // which read as unsigned is exactly its magnitude (e.g. 8-bit 0x80 -> 128).
   // ---------------------------------------------------------------------------
   logic                  din_neg;
   logic [WIDTH-1:0]      din_mag;

   assign din_neg = (SIGNED != 0) && din[WIDTH-1];
   assign din_mag = din_neg ? (~din + {{(WIDTH-1){1'b0}}, 1'b1}) : din;

   // ---------------------------------------------------------------------------
   // Double-dabble digit adjustment: every digit >= 5 gets +3 so that the
   // following left shift produces a correct decimal carry into the next digit.
   // ---------------------------------------------------------------------------
   logic [4*DIGITS-1:0]   bcd_adj;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         logic [3:0] dig;
         assign dig                  = bcd_q[4*gi +: 4];
         assign bcd_adj[4*gi +: 4]   = (dig >= 4'd5) ? (dig + 4'd3) : dig;
      end
   endgenerate

   // Shift of the {digits, magnitude} chain: the magnitude MSB enters the
   // units digit and the MSB of the (adjusted) top digit falls off the end.
   // A 1 falling off means the value has reached 10^DIGITS.
   logic [4*DIGITS-1:0]   bcd_shift;
   logic [WIDTH-1:0]      mag_shift;
   logic                  carry_out;

   assign bcd_shift = {bcd_adj[4*DIGITS-2:0], mag_q[WIDTH-1]};
   assign mag_shift = {mag_q[WIDTH-2:0], 1'b0};
   assign carry_out = bcd_adj[4*DIGITS-1];

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mag_q   <= '0;
         bcd_q   <= '0;
         sign_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         bcd_q   <= bcd_d;
         sign_q  <= sign_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      mag_d     = mag_q;
      bcd_d     = bcd_q;
      sign_d    = sign_q;
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            // Result registers keep the previous conversion until a new
            // value is accepted.
            if (in_valid) begin
               mag_d   = din_mag;
               bcd_d   = '0;
               ovf_d   = 1'b0;
               sign_d  = din_neg;
               cnt_d   = CNT_LOAD;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            busy  = 1'b1;
            mag_d = mag_shift;
            bcd_d = bcd_shift;
            ovf_d = ovf_q | carry_out;
            cnt_d = cnt_q - CNT_ONE;
            // Counter was loaded with WIDTH-1, so the step taken while it
            // reads 0 is the WIDTH-th and last one.
            if (cnt_q == '0) begin
               state_d = DONE;
            end
         end

         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bcd      = bcd_q;
   assign sign     = sign_q;
   assign overflow = ovf_q;

endmodule
